// File: rtl/dmem_block_reader_if.sv
// Memory-port and word-stream signals shared by the block reader and its peers.
// The master modport is the reader's view; the slave modport is the memory/consumer view.
interface dmem_block_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              RdRam;
  logic              WrRam;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Out_Data;
  logic [DATA_W-1:0] M_Data;
  logic              M_Valid;
  logic              M_Ready;
  logic              M_Last;

  modport master (
    output RdRam, WrRam, Addr, M_Data, M_Valid, M_Last,
    input  Out_Data, M_Ready
  );

  modport slave (
    input  RdRam, WrRam, Addr, M_Data, M_Valid, M_Last,
    output Out_Data, M_Ready
  );
endinterface

// File: rtl/dmem_block_reader.sv
// Read-only master that walks a contiguous range of the data memory and streams
// each word out over valid/ready with a last-word flag.
module dmem_block_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [ADDR_W:0]   Length,
  output logic              Busy,
  output logic              Done,
  dmem_block_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [2:0]    LAT_INIT = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

  state_t              state_q;
  logic [ADDR_W-1:0]   curAddr_q;
  logic [ADDR_W:0]     remaining_q;
  logic [2:0]          latCnt_q;
  logic                rdRam_q;
  logic [DATA_W-1:0]   mData_q;
  logic                mValid_q;
  logic                mLast_q;
  logic                busy_q;
  logic                done_q;

  logic [ADDR_W-1:0]   addrInc_d;
  logic [ADDR_W:0]     remDec_d;
  logic                lastWord;

  // Address wraps naturally at 2^ADDR_W, so a full-size transfer touches every word once.
  assign addrInc_d = curAddr_q + ADDR_W'(1);
  assign remDec_d  = remaining_q - REM_ONE;
  assign lastWord  = (remaining_q == REM_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      curAddr_q   <= '0;
      remaining_q <= '0;
      latCnt_q    <= '0;
      rdRam_q     <= 1'b0;
      mData_q     <= '0;
      mValid_q    <= 1'b0;
      mLast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            busy_q <= 1'b1;
            if (Length != '0) begin
              curAddr_q   <= Base_Addr;
              remaining_q <= Length;
              rdRam_q     <= 1'b1;
              state_q     <= S_ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (RD_LAT == 0) begin
            mData_q  <= bus.Out_Data;
            rdRam_q  <= 1'b0;
            mValid_q <= 1'b1;
            mLast_q  <= lastWord;
            state_q  <= S_HOLD;
          end else begin
            latCnt_q <= LAT_INIT;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (latCnt_q == '0) begin
            mData_q  <= bus.Out_Data;
            rdRam_q  <= 1'b0;
            mValid_q <= 1'b1;
            mLast_q  <= lastWord;
            state_q  <= S_HOLD;
          end else begin
            latCnt_q <= latCnt_q - 3'd1;
          end
        end
        // M_Valid is always high here, so M_Ready alone completes the handshake.
        S_HOLD: begin
          if (bus.M_Ready) begin
            mValid_q <= 1'b0;
            mLast_q  <= 1'b0;
            if (lastWord) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              curAddr_q   <= addrInc_d;
              remaining_q <= remDec_d;
              rdRam_q     <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.RdRam   = rdRam_q;
  assign bus.WrRam   = 1'b0;
  assign bus.Addr    = curAddr_q;
  assign bus.M_Data  = mData_q;
  assign bus.M_Valid = mValid_q;
  assign bus.M_Last  = mLast_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_dmem_block_reader.sv
// Directed bench for dmem_block_reader: one instance with a 1-cycle memory and one
// with a combinational memory, sharing a preloaded memory array.
module tb_dmem_block_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [10:0] base0, base1;
  logic [11:0] len0, len1;
  logic        mReady0, mReady1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] mem [0:2047];

  int checks = 0;
  int failures = 0;

  logic [15:0] wData[$];
  bit          wLast[$];
  int          wCyc[$];
  int          rdRuns[$];
  logic [10:0] rdAddrs[$];
  int          doneCnt, doneCyc, wrViol, addrMoveViol, stallViol, rdDuringStall;
  bit          timedOut;
  logic        busyFirst, busyAfter;

  dmem_block_reader_if #(.ADDR_W(11), .DATA_W(16)) bus0 ();
  dmem_block_reader_if #(.ADDR_W(11), .DATA_W(16)) bus1 ();

  dmem_block_reader #(.ADDR_W(11), .DATA_W(16), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .Start(start0), .Base_Addr(base0), .Length(len0),
    .Busy(busy0), .Done(done0), .bus(bus0.master)
  );

  dmem_block_reader #(.ADDR_W(11), .DATA_W(16), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Start(start1), .Base_Addr(base1), .Length(len1),
    .Busy(busy1), .Done(done1), .bus(bus1.master)
  );

  always #5 clk = ~clk;

  // Combinational memory for dut0, registered-read memory for dut1.
  assign bus0.Out_Data = mem[bus0.Addr];
  assign bus0.M_Ready  = mReady0;
  assign bus1.M_Ready  = mReady1;
  always @(posedge clk) if (bus1.RdRam) bus1.Out_Data <= mem[bus1.Addr];

  // Runs one transfer cycle by cycle on the selected instance (sel=1 -> dut0), recording
  // accepted words, RdRam pulse widths/addresses and Done timing; optional stall and mid-transfer Start.
  task automatic runXfer(input bit sel, input int stallWord, input int stallCycles,
                         input int midStart, input int maxCycles);
    bit prevRd = 1'b0;
    int runLen = 0;
    int stallCnt = 0;
    int tail = -1;
    logic [15:0] stallData = '0;
    logic [10:0] prevAddr = '0;
    logic rd, valid, last, done, busy;
    logic [10:0] addr;
    logic [15:0] data;
    wData.delete(); wLast.delete(); wCyc.delete(); rdRuns.delete(); rdAddrs.delete();
    doneCnt = 0; doneCyc = -1; wrViol = 0; addrMoveViol = 0; stallViol = 0; rdDuringStall = 0;
    timedOut = 1'b1; busyFirst = 1'b0; busyAfter = 1'b1;
    for (int c = 0; c < maxCycles; c++) begin
      rd    = sel ? bus0.RdRam   : bus1.RdRam;
      addr  = sel ? bus0.Addr    : bus1.Addr;
      data  = sel ? bus0.M_Data  : bus1.M_Data;
      valid = sel ? bus0.M_Valid : bus1.M_Valid;
      last  = sel ? bus0.M_Last  : bus1.M_Last;
      done  = sel ? done0        : done1;
      busy  = sel ? busy0        : busy1;
      if (bus0.WrRam !== 1'b0 || bus1.WrRam !== 1'b0) wrViol++;
      if (c == 0) busyFirst = busy;
      if (doneCyc >= 0 && c == doneCyc + 1) busyAfter = busy;
      if (rd) begin
        if (!prevRd) rdAddrs.push_back(addr);
        else if (addr !== prevAddr) addrMoveViol++;
        runLen++;
      end else if (prevRd) begin
        rdRuns.push_back(runLen);
        runLen = 0;
      end
      prevRd = rd;
      prevAddr = addr;
      if (sel) begin
        start0 = (c == midStart); base0 = 11'd100; len0 = 12'd7;
      end else begin
        start1 = (c == midStart); base1 = 11'd100; len1 = 12'd7;
      end
      if (stallCnt > 0 && stallCnt < stallCycles && !valid) stallViol++;
      if (valid) begin
        if (wData.size() == stallWord && stallCnt < stallCycles) begin
          if (stallCnt == 0) stallData = data;
          else if (data !== stallData) stallViol++;
          if (rd) rdDuringStall++;
          stallCnt++;
          mReady0 = 1'b0; mReady1 = 1'b0;
        end else begin
          mReady0 = 1'b1; mReady1 = 1'b1;
          wData.push_back(data); wLast.push_back(last); wCyc.push_back(c);
        end
      end else begin
        mReady0 = 1'b1; mReady1 = 1'b1;
      end
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCyc < 0) begin doneCyc = c; tail = 3; end
      end
      if (tail == 0) begin timedOut = 1'b0; break; end
      if (tail > 0) tail--;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus1.RdRam, bus1.WrRam, bus1.M_Valid, bus1.M_Last, busy1, done1} !== 6'b0) begin
      failures++; $display("[TB] FAIL reset_ctrl got=%b exp=000000",
        {bus1.RdRam, bus1.WrRam, bus1.M_Valid, bus1.M_Last, busy1, done1});
    end
    checks++;
    if (bus1.Addr !== 11'd0 || bus1.M_Data !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_bus got=%h/%h exp=0/0", bus1.Addr, bus1.M_Data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_idle_busy got=%b%b exp=00", busy0, busy1);
    end
  endtask

  task automatic test_stream();
    logic [15:0] expD [3];
    expD = '{16'hA5A5, 16'h1234, 16'hFFFF};
    @(negedge clk); start1 = 1'b1; base1 = 11'd5; len1 = 12'd3;
    @(negedge clk);
    runXfer(1'b0, -1, 0, -1, 60);
    checks++; if (timedOut) begin failures++; $display("[TB] FAIL stream_timeout got=1 exp=0"); end
    checks++; if (busyFirst !== 1'b1) begin failures++; $display("[TB] FAIL stream_busy_first got=%b exp=1", busyFirst); end
    checks++; if (wData.size() != 3) begin failures++; $display("[TB] FAIL stream_count got=%0d exp=3", wData.size()); end
    if (wData.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wData[i] !== expD[i] || wLast[i] !== (i == 2) || wCyc[i] != 2 + 3 * i) begin
          failures++;
          $display("[TB] FAIL stream_word[%0d] got=%h last=%b cyc=%0d exp=%h last=%b cyc=%0d",
                   i, wData[i], wLast[i], wCyc[i], expD[i], (i == 2), 2 + 3 * i);
        end
      end
    end
    checks++;
    if (rdRuns.size() != 3 || rdRuns[0] != 2 || rdRuns[1] != 2 || rdRuns[2] != 2) begin
      failures++; $display("[TB] FAIL stream_rd_width got=%p exp=2,2,2", rdRuns);
    end
    checks++;
    if (rdAddrs.size() != 3 || rdAddrs[0] !== 11'd5 || rdAddrs[2] !== 11'd7 || addrMoveViol != 0) begin
      failures++; $display("[TB] FAIL stream_addr got=%p moves=%0d exp=5,6,7 moves=0", rdAddrs, addrMoveViol);
    end
    checks++;
    if (doneCnt != 1 || doneCyc != 9) begin
      failures++; $display("[TB] FAIL stream_done got=cnt%0d cyc%0d exp=cnt1 cyc9", doneCnt, doneCyc);
    end
    checks++; if (busyAfter !== 1'b0) begin failures++; $display("[TB] FAIL stream_busy_after got=%b exp=0", busyAfter); end
    checks++; if (wrViol != 0) begin failures++; $display("[TB] FAIL stream_wrram got=%0d exp=0", wrViol); end
  endtask

  task automatic test_stall();
    @(negedge clk); start1 = 1'b1; base1 = 11'd5; len1 = 12'd3;
    @(negedge clk);
    runXfer(1'b0, 1, 10, -1, 80);
    checks++; if (timedOut) begin failures++; $display("[TB] FAIL stall_timeout got=1 exp=0"); end
    checks++;
    if (wCyc.size() != 3 || wCyc[0] != 2 || wCyc[1] != 15 || wCyc[2] != 18) begin
      failures++; $display("[TB] FAIL stall_timing got=%p exp=2,15,18", wCyc);
    end
    checks++;
    if (wData.size() != 3 || wData[1] !== 16'h1234 || wData[2] !== 16'hFFFF) begin
      failures++; $display("[TB] FAIL stall_data got=%p exp=a5a5,1234,ffff", wData);
    end
    checks++;
    if (stallViol != 0 || rdDuringStall != 0) begin
      failures++; $display("[TB] FAIL stall_stable got=viol%0d rd%0d exp=viol0 rd0", stallViol, rdDuringStall);
    end
    checks++;
    if (doneCnt != 1 || doneCyc != 19 || rdRuns.size() != 3) begin
      failures++; $display("[TB] FAIL stall_done got=cnt%0d cyc%0d runs%0d exp=cnt1 cyc19 runs3",
                           doneCnt, doneCyc, rdRuns.size());
    end
  endtask

  task automatic test_wrap();
    logic [15:0] expD [4];
    logic [10:0] expA [4];
    expD = '{16'hBEEF, 16'hCAFE, 16'h0001, 16'h7E57};
    expA = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    @(negedge clk); start1 = 1'b1; base1 = 11'd2046; len1 = 12'd4;
    @(negedge clk);
    runXfer(1'b0, -1, 0, -1, 80);
    checks++;
    if (timedOut || wData.size() != 4 || rdAddrs.size() != 4) begin
      failures++; $display("[TB] FAIL wrap_count got=%0d/%0d to=%b exp=4/4 to=0", wData.size(), rdAddrs.size(), timedOut);
    end
    if (wData.size() == 4 && rdAddrs.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rdAddrs[i] !== expA[i] || wData[i] !== expD[i] || wLast[i] !== (i == 3)) begin
          failures++;
          $display("[TB] FAIL wrap_word[%0d] got=%0d:%h last=%b exp=%0d:%h last=%b",
                   i, rdAddrs[i], wData[i], wLast[i], expA[i], expD[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_zero_length();
    @(negedge clk); start1 = 1'b1; base1 = 11'd5; len1 = 12'd0;
    @(negedge clk);
    runXfer(1'b0, -1, 0, -1, 20);
    checks++;
    if (timedOut || doneCyc != 0 || doneCnt != 1) begin
      failures++; $display("[TB] FAIL zero_done got=cyc%0d cnt%0d exp=cyc0 cnt1", doneCyc, doneCnt);
    end
    checks++;
    if (busyFirst !== 1'b1 || busyAfter !== 1'b0) begin
      failures++; $display("[TB] FAIL zero_busy got=%b%b exp=10", busyFirst, busyAfter);
    end
    checks++;
    if (rdAddrs.size() != 0 || wData.size() != 0) begin
      failures++; $display("[TB] FAIL zero_access got=rd%0d words%0d exp=rd0 words0", rdAddrs.size(), wData.size());
    end
  endtask

  task automatic test_abort_reset();
    int lateDone = 0;
    int lateValid = 0;
    mReady1 = 1'b1;
    @(negedge clk); start1 = 1'b1; base1 = 11'd5; len1 = 12'd5;
    @(negedge clk); start1 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus1.RdRam !== 1'b1 || bus1.Addr !== 11'd6 || bus1.M_Data !== 16'hA5A5) begin
      failures++; $display("[TB] FAIL abort_pre got=%b/%0d/%h exp=1/6/a5a5", bus1.RdRam, bus1.Addr, bus1.M_Data);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus1.RdRam, bus1.WrRam, bus1.M_Valid, bus1.M_Last, busy1, done1} !== 6'b0 ||
        bus1.Addr !== 11'd0 || bus1.M_Data !== 16'd0) begin
      failures++; $display("[TB] FAIL abort_async got=%b %h %h exp=000000 0 0",
        {bus1.RdRam, bus1.WrRam, bus1.M_Valid, bus1.M_Last, busy1, done1}, bus1.Addr, bus1.M_Data);
    end
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done1 !== 1'b0) lateDone++;
      if (bus1.M_Valid !== 1'b0 || bus1.RdRam !== 1'b0) lateValid++;
    end
    checks++;
    if (lateDone != 0 || lateValid != 0) begin
      failures++; $display("[TB] FAIL abort_quiet got=done%0d act%0d exp=done0 act0", lateDone, lateValid);
    end
    start1 = 1'b1; base1 = 11'd6; len1 = 12'd2;
    @(negedge clk);
    runXfer(1'b0, -1, 0, -1, 40);
    checks++;
    if (timedOut || wData.size() != 2 || rdAddrs.size() != 2 || rdAddrs[0] !== 11'd6 ||
        wData[0] !== 16'h1234 || wData[1] !== 16'hFFFF || wLast[1] !== 1'b1 || wLast[0] !== 1'b0) begin
      failures++; $display("[TB] FAIL abort_restart got=%p addrs=%p exp=1234,ffff addrs=6,7", wData, rdAddrs);
    end
  endtask

  task automatic test_lat0_ignore_start();
    @(negedge clk); start0 = 1'b1; base0 = 11'd5; len0 = 12'd2;
    @(negedge clk);
    runXfer(1'b1, -1, 0, 1, 40);
    checks++;
    if (timedOut || wCyc.size() != 2 || wCyc[0] != 1 || wCyc[1] != 3) begin
      failures++; $display("[TB] FAIL lat0_timing got=%p exp=1,3", wCyc);
    end
    checks++;
    if (wData.size() != 2 || wData[0] !== 16'hA5A5 || wData[1] !== 16'h1234 || wLast[1] !== 1'b1) begin
      failures++; $display("[TB] FAIL lat0_data got=%p exp=a5a5,1234", wData);
    end
    checks++;
    if (rdRuns.size() != 2 || rdRuns[0] != 1 || rdRuns[1] != 1 || rdAddrs[1] !== 11'd6) begin
      failures++; $display("[TB] FAIL lat0_rd got=%p addrs=%p exp=1,1 addrs=5,6", rdRuns, rdAddrs);
    end
    checks++;
    if (doneCnt != 1 || doneCyc != 4 || busyAfter !== 1'b0) begin
      failures++; $display("[TB] FAIL lat0_ignore got=cnt%0d cyc%0d busy%b exp=cnt1 cyc4 busy0",
                           doneCnt, doneCyc, busyAfter);
    end
    checks++; if (wrViol != 0) begin failures++; $display("[TB] FAIL lat0_wrram got=%0d exp=0", wrViol); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[5] = 16'hA5A5; mem[6] = 16'h1234; mem[7] = 16'hFFFF;
    mem[8] = 16'h0F0F; mem[9] = 16'h8001;
    mem[2046] = 16'hBEEF; mem[2047] = 16'hCAFE; mem[0] = 16'h0001; mem[1] = 16'h7E57;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; base0 = '0; base1 = '0; len0 = '0; len1 = '0;
    mReady0 = 1'b1; mReady1 = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_wrap();
    test_zero_length();
    test_abort_reset();
    test_lat0_ignore_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_block_reader.md
Name: dmem_block_reader

Overview:
- Read-side master for the BIP data memory: walks a contiguous address range, drives RdRam/Addr, captures Out_Data and streams each word out on a valid/ready interface with a last-word flag.
- Sits between Data_Memory and the debug/readout path, for example a UART dump of RAM after program halt.
- Never writes memory; WrRam is driven low permanently, and the block is muxed with the CPU on the memory port while Busy=1.

Parameters:
- ADDR_W, 11, memory address width (2048 words).
- DATA_W, 16, memory word width.
- RD_LAT, 1, cycles between first RdRam cycle and the Out_Data sample edge (0 = combinational memory); legal range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Base_Addr  in  ADDR_W  first address; latched on accepted Start.
- Length  in  ADDR_W+1  word count 0..2048; latched on accepted Start.
- Busy  out  1  high from the cycle after accepted Start through the DONE cycle inclusive.
- Done  out  1  one-cycle pulse at end of transfer.
- RdRam  out  1  memory read enable.
- WrRam  out  1  constant 0.
- Addr  out  ADDR_W  memory address.
- Out_Data  in  DATA_W  memory read data.
- M_Data  out  DATA_W  captured word.
- M_Valid  out  1  M_Data valid.
- M_Ready  in  1  consumer ready.
- M_Last  out  1  high with M_Valid on the final word.

Behaviour:
- Reset (async assert, sync release), all states: state=IDLE; RdRam=0, WrRam=0, Addr=0, M_Data=0, M_Valid=0, M_Last=0, Busy=0, Done=0; counters cleared.
- Reset mid-transfer aborts immediately. No Done pulse and no partial word are emitted.
- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - Start=1 and Length!=0: latch cur_addr=Base_Addr and remaining=Length, go to ISSUE.
  - Start=1 and Length=0: go to DONE with no memory access.
- ISSUE: RdRam=1, Addr=cur_addr. If RD_LAT=0, capture Out_Data into M_Data at the end of this cycle and go to HOLD. Otherwise load lat_cnt=RD_LAT-1 and go to WAIT.
- WAIT: RdRam=1 and Addr held. When lat_cnt=0, capture Out_Data at the end of the cycle and go to HOLD. Otherwise decrement lat_cnt.
- Hence RdRam is high for exactly RD_LAT+1 consecutive cycles per word, with Addr stable throughout.
- HOLD:
  - RdRam=0, M_Valid=1, M_Last=(remaining==1). M_Data and M_Last stay stable until the handshake.
  - On M_Valid&M_Ready: if remaining==1 go to DONE; else cur_addr+=1, remaining-=1, go to ISSUE.
  - M_Ready is ignored outside HOLD.
- DONE: Done=1 for one cycle, M_Valid=0, then IDLE.
- Addr increment wraps modulo 2^ADDR_W (2047 -> 0). Length=2048 reads every word exactly once.
- Start while not IDLE is ignored. Base_Addr/Length changes after latch have no effect.
- Throughput with M_Ready held high: one word per RD_LAT+2 cycles.
- Addr keeps its last driven value while idle. RdRam=0 outside ISSUE/WAIT.

Test Plan:
- Preload mem[5..7]=0xA5A5,0x1234,0xFFFF; RD_LAT=1; Start with Base_Addr=5, Length=3; M_Ready=1 -> words A5A5,1234,FFFF in order, M_Last only on FFFF, one word every 3 cycles, single Done pulse, each RdRam pulse 2 cycles wide.
- Base_Addr=2046, Length=4 -> Addr sequence 2046,2047,0,1; data matches preload.
- M_Ready held low 10 cycles on word 2 -> M_Valid and M_Data stay stable, no new RdRam during the stall, transfer resumes on release.
- Length=0 -> Done one cycle after Start, Busy high that cycle only, RdRam never asserted, M_Valid never asserted.
- rst_n pulsed low during WAIT of word 2 of 5 -> all outputs 0 asynchronously, no Done; a new Start after release restarts from the new Base_Addr.
- RD_LAT=0, Length=2, second Start issued mid-transfer -> RdRam 1 cycle per word, the second Start is ignored, WrRam is 0 throughout every test.
